truth_table_sweeper: RTL

- Sequential stimulus/capture engine for 4-input combinational experiment circuits.
- Drives the 4-bit input vector of a device under test (DUT) from 0 through 15, dwelling a fixed number of clocks on each value.
- Samples the DUT's single-bit output F on each vector, assembles the captured 16-bit truth table, and compares it against a golden table supplied at start.
- Sits between the control/display logic and the combinational block under test.

---
 rtl/truth_table_sweeper_if.sv | 23 ++
 rtl/truth_table_sweeper.sv | 121 ++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its controller / experiment circuit.
// The master side drives start, golden table and the experiment output f.
interface truth_table_sweeper_if;
  logic        start_i;
  logic [15:0] expected_i;
  logic        f_i;
  logic [3:0]  n_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] table_o;
  logic [4:0]  mismatch_cnt_o;

  modport master (
    output start_i, expected_i, f_i,
    input  n_o, busy_o, done_o, pass_o, table_o, mismatch_cnt_o
  );

  modport slave (
    input  start_i, expected_i, f_i,
    output n_o, busy_o, done_o, pass_o, table_o, mismatch_cnt_o
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 4-bit vector 0..15 with DWELL clocks per value, captures f and compares to a golden table.
// Optional: SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
  parameter int unsigned DWELL = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  sw_if
);

  localparam int unsigned NW    = 4;
  localparam int unsigned TW    = 16;
  localparam int unsigned MW    = 5;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [NW-1:0]    n_q,     n_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             pass_q,  pass_d;
  logic [TW-1:0]    table_q, table_d;
  logic [MW-1:0]    mis_q,   mis_d;
  logic [TW-1:0]    exp_q,   exp_d;
  logic             miss_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= '0;
      mis_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      exp_q   <= exp_d;
    end
  end

  assign miss_c = (sw_if.f_i != exp_q[n_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    table_d = table_q;
    mis_d   = mis_q;
    exp_d   = exp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sw_if.start_i) begin
          exp_d   = sw_if.expected_i;
          n_d     = '0;
          table_d = '0;
          mis_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SWEEP;
        end
      end

      ST_SWEEP: begin
        if (cnt_q == CNT_LAST) begin
          // Sample on the last dwell clock; n only moves on this boundary.
          cnt_d          = '0;
          table_d[n_q]   = sw_if.f_i;
          if (miss_c) mis_d = mis_q + MW'(1);
`ifdef SWEEP_STOP_ON_FAIL_EN
          if (miss_c || (n_q == NW'(15))) state_d = ST_FINISH;
          else                            n_d     = n_q + NW'(1);
`else
          if (n_q == NW'(15)) state_d = ST_FINISH;
          else                n_d     = n_q + NW'(1);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (mis_q == '0);
        n_d     = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sw_if.n_o            = n_q;
  assign sw_if.busy_o         = busy_q;
  assign sw_if.done_o         = done_q;
  assign sw_if.pass_o         = pass_q;
  assign sw_if.table_o        = table_q;
  assign sw_if.mismatch_cnt_o = mis_q;

endmodule
